// File: rtl/lab4_q3_alu_pkg.sv
// Shared types for the execute-stage ALU: opcode encoding and the
// combined result/flag bundle passed from the core to the output register.
package lab4_q3_alu_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SGT  = 4'b0010,
    OP_SGTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              n;
    logic              z;
    logic              v;
    logic              c;
    logic              hata;
  } alu_out_t;
endpackage

// File: rtl/lab4_q3_alu_core.sv
// Combinational ALU datapath: result, N/Z/V/C flags and illegal-opcode error.
module lab4_q3_alu_core
  import lab4_q3_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        op_i,
  output alu_out_t          out_o
);

  logic [4:0]        sh;
  logic [DATA_W:0]   sum, diff, shl, shr, sra;
  logic [DATA_W-1:0] r;
  logic              cf, vf, bad;

  // Shifts run one bit wider so the last bit shifted out lands in a fixed
  // position; with sh=0 that extra bit is zero, giving c=0 for free.
  assign sh   = b_i[4:0];
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
  assign shl  = {1'b0, a_i} << sh;
  assign shr  = {a_i, 1'b0} >> sh;
  assign sra  = $signed({a_i, 1'b0}) >>> sh;

  always_comb begin
    r   = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    bad = 1'b0;
    case (op_i)
      OP_ADD: begin
        r  = sum[DATA_W-1:0];
        cf = sum[DATA_W];
        vf = (a_i[31] == b_i[31]) && (r[31] != a_i[31]);
      end
      OP_SUB: begin
        r  = diff[DATA_W-1:0];
        cf = diff[DATA_W];
        vf = (a_i[31] != b_i[31]) && (r[31] != a_i[31]);
      end
      OP_AND:  r = a_i & b_i;
      OP_OR:   r = a_i | b_i;
      OP_XOR:  r = a_i ^ b_i;
      OP_SLL: begin
        r  = shl[DATA_W-1:0];
        cf = shl[DATA_W];
      end
      OP_SRL: begin
        r  = shr[DATA_W:1];
        cf = shr[0];
      end
      OP_SRA: begin
        r  = sra[DATA_W:1];
        cf = sra[0];
      end
      OP_SGT:  r = {31'd0, $signed(a_i) > $signed(b_i)};
      OP_SGTU: r = {31'd0, a_i > b_i};
      default: bad = 1'b1;
    endcase

    out_o      = '0;
    out_o.hata = bad;
    if (!bad) begin
      out_o.res = r;
      out_o.n   = r[31];
      out_o.z   = (r == '0);
      out_o.v   = vf;
      out_o.c   = cf;
    end
  end

endmodule

// File: rtl/lab4_q3_a_m_alu.sv
// Execute-stage ALU: combinational core followed by one output register stage.
module lab4_q3_a_m_alu
  import lab4_q3_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] res,
  output logic              hata,
  output logic              v,
  output logic              z,
  output logic              n,
  output logic              c
);

  alu_out_t out_d, out_q;

  lab4_q3_alu_core u_core (
    .a_i   (a),
    .b_i   (b),
    .op_i  (op),
    .out_o (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign res  = out_q.res;
  assign hata = out_q.hata;
  assign v    = out_q.v;
  assign z    = out_q.z;
  assign n    = out_q.n;
  assign c    = out_q.c;

endmodule

// File: tb/tb_lab4_q3_a_m_alu.sv
// Scoreboard bench for the ALU: directed and random stimulus against an
// arithmetic reference model, checked by a separate per-cycle monitor.
module tb_lab4_q3_a_m_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        n, z, v, c, hata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic [31:0] res;
  logic        hata, v, z, n, c;

  exp_t exp_q[$];
  int   npass = 0;
  int   ntot  = 0;

  lab4_q3_a_m_alu dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .res(res), .hata(hata), .v(v), .z(z), .n(n), .c(c)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [3:0] eop, input logic erst);
    exp_t   e;
    longint sa, sb, s;
    int     sh;
    e  = '0;
    sa = longint'($signed(ea));
    sb = longint'($signed(eb));
    sh = int'(eb[4:0]);
    if (erst) return e;
    case (eop)
      4'b0000: begin
        e.res = ea + eb;
        e.c   = (longint'(ea) + longint'(eb)) > 64'sd4294967295;
        s     = sa + sb;
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1000: begin
        e.res = ea - eb;
        e.c   = (ea >= eb);
        s     = sa - sb;
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = ea & eb;
      4'b0110: e.res = ea | eb;
      4'b0100: e.res = ea ^ eb;
      4'b0001: begin
        e.res = ea << sh;
        e.c   = (sh == 0) ? 1'b0 : ea[32 - sh];
      end
      4'b0101: begin
        e.res = ea >> sh;
        e.c   = (sh == 0) ? 1'b0 : ea[sh - 1];
      end
      4'b1101: begin
        e.res = $signed(ea) >>> sh;
        e.c   = (sh == 0) ? 1'b0 : ea[sh - 1];
      end
      4'b0010: e.res = (sa > sb) ? 32'd1 : 32'd0;
      4'b0011: e.res = (ea > eb) ? 32'd1 : 32'd0;
      default: e.hata = 1'b1;
    endcase
    if (!e.hata) begin
      e.n = e.res[31];
      e.z = (e.res == 32'd0);
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [3:0] iop, input logic irst);
    @(negedge clk);
    a   = ia;
    b   = ib;
    op  = iop;
    rst = irst;
    exp_q.push_back(model(ia, ib, iop, irst));
  endtask

  // Monitor: output is presented every cycle, one expected entry per edge.
  always @(posedge clk) begin
    exp_t e, got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{res: res, n: n, z: z, v: v, c: c, hata: hata};
      ntot++;
      if (got === e) npass++;
      else $display("FAIL alu_out op=%b a=%h b=%h: got res=%h nzvc=%b%b%b%b hata=%b, want res=%h nzvc=%b%b%b%b hata=%b",
                    op, a, b, got.res, got.n, got.z, got.v, got.c, got.hata,
                    e.res, e.n, e.z, e.v, e.c, e.hata);
    end
  end

  logic [31:0] da [19];
  logic [31:0] db [19];
  logic [3:0]  dop[19];

  initial begin
    da[0]  = 32'h9CC3503B; db[0]  = 32'hE71BC249; dop[0]  = 4'b0000;
    da[1]  = 32'hF873BF41; db[1]  = 32'h692290A9; dop[1]  = 4'b1000;
    da[2]  = 32'h0D44DCE6; db[2]  = 32'hB3835193; dop[2]  = 4'b1000;
    da[3]  = 32'h843003CE; db[3]  = 32'h00D6E3CF; dop[3]  = 4'b0111;
    da[4]  = 32'hF065C7E0; db[4]  = 32'h607139B8; dop[4]  = 4'b0110;
    da[5]  = 32'h9582E078; db[5]  = 32'h553820B2; dop[5]  = 4'b0100;
    da[6]  = 32'hF20C1979; db[6]  = 32'h2B03F426; dop[6]  = 4'b0001;
    da[7]  = 32'h2A260AA5; db[7]  = 32'h3197E016; dop[7]  = 4'b0101;
    da[8]  = 32'h59B7140B; db[8]  = 32'h24896367; dop[8]  = 4'b1101;
    da[9]  = 32'h80000000; db[9]  = 32'h00000004; dop[9]  = 4'b1101;
    da[10] = 32'h00986726; db[10] = 32'h86EA89FA; dop[10] = 4'b0010;
    da[11] = 32'hD0F361A2; db[11] = 32'hE0B583CE; dop[11] = 4'b0010;
    da[12] = 32'hE033E9A9; db[12] = 32'h0A8A9993; dop[12] = 4'b0011;
    da[13] = 32'h664B9F3E; db[13] = 32'hB73BE41F; dop[13] = 4'b0011;
    da[14] = 32'h12345678; db[14] = 32'h9ABCDEF0; dop[14] = 4'b1111;
    da[15] = 32'h7FFFFFFF; db[15] = 32'h00000001; dop[15] = 4'b0000;
    da[16] = 32'h80000000; db[16] = 32'h00000001; dop[16] = 4'b1000;
    da[17] = 32'h00000000; db[17] = 32'h00000001; dop[17] = 4'b1000;
    da[18] = 32'hDEADBEEF; db[18] = 32'h00000020; dop[18] = 4'b0001;

    rst = 1'b1; a = '0; b = '0; op = '0;
    issue(32'hFFFFFFFF, 32'h1, 4'b0000, 1'b1);
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 4'b1010, 1'b1);
    for (int i = 0; i < 19; i++) issue(da[i], db[i], dop[i], 1'b0);
    issue(32'h1, 32'h1, 4'b0000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom();
      if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h7FFFFFFF} ^ {1'b0, ra[31] ? 31'h7FFFFFFF : 31'h0};
      issue(ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
    end
    issue('0, '0, 4'b0000, 1'b0);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      ntot++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
